camera_downsampler: RTL and testbench
=====================================

CAMERA_DOWNSAMPLER -- requirements
Module: camera_downsampler

Interface
REQ-001 SCREEN_WIDTH, default 176: active pixels per line written to the frame buffer.
REQ-002 SCREEN_HEIGHT, default 144: active lines per frame written to the frame buffer.
REQ-003 CLK  input  1  camera pixel clock; the single clock, all logic on posedge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 CAM_DATA  input  8  camera byte bus: RGB565, high byte first.
REQ-006 CAM_HREF  input  1  high while a line's bytes are valid.
REQ-007 CAM_VSYNC  input  1  high during vertical blanking; rising edge ends a frame.
REQ-008 PIXEL_OUT  output  8  RGB332 pixel to the frame buffer / image processor.
REQ-009 W_EN  output  1  one-cycle frame-buffer write strobe for PIXEL_OUT.
REQ-010 X_ADDR  output  8  column of PIXEL_OUT, 0..SCREEN_WIDTH-1.
REQ-011 Y_ADDR  output  8  row of PIXEL_OUT, 0..SCREEN_HEIGHT-1.
REQ-012 FRAME_DONE  output  1  one-cycle pulse on each frame end.

Function
REQ-013 CAM_HREF and CAM_VSYNC shall be registered once; edges are detected against that registered copy.
REQ-014 States: WAIT_FRAME (idle after reset, ignores HREF until the first VSYNC falling edge) and CAPTURE.
REQ-015 WAIT_FRAME -> CAPTURE on VSYNC falling edge; CAPTURE -> WAIT_FRAME never except by reset.
REQ-016 In CAPTURE, while CAM_HREF is high, a byte-phase bit shall toggle every cycle, starting at phase 0 on the first HREF-high cycle.
REQ-017 Phase 0 byte: hold CAM_DATA[7:5] as R and CAM_DATA[2:0] as G.
REQ-018 Phase 1 byte: form PIXEL_OUT = {R, G, CAM_DATA[4:3]}, i.e. RGB565 truncated to RGB332.
REQ-019 PIXEL_OUT, X_ADDR, Y_ADDR and W_EN shall be registered and valid together on the cycle after the phase-1 byte (latency 1 cycle from second byte).
REQ-020 W_EN shall assert only if the column counter < SCREEN_WIDTH and the row counter < SCREEN_HEIGHT; excess pixels/lines are dropped silently.
REQ-021 After each completed pixel the column counter shall increment and saturate at SCREEN_WIDTH (no wrap within a line).
REQ-022 On HREF falling edge: column counter := 0, byte phase := 0, row counter += 1 saturating at SCREEN_HEIGHT; a dangling phase-0 byte is discarded.
REQ-023 On VSYNC rising edge: row counter := 0, column counter := 0, phase := 0, FRAME_DONE asserted for exactly one cycle.
REQ-024 HREF high while VSYNC is high shall be ignored (no writes, no counter change).
REQ-025 Simultaneous HREF fall and VSYNC rise: VSYNC rule (REQ-023) wins.
REQ-026 X_ADDR/Y_ADDR and PIXEL_OUT shall hold their last values when W_EN is low.

Reset
REQ-027 RESET_N low shall immediately force state WAIT_FRAME, counters 0, phase 0, PIXEL_OUT 8'h00, X_ADDR 0, Y_ADDR 0, W_EN 0, FRAME_DONE 0.
REQ-028 Reset asserted mid-line shall abort the pixel; no W_EN shall be produced for a partial pixel after release.
REQ-029 After reset release, capture shall restart only at the next VSYNC falling edge.

Structure
REQ-030 SCREEN_WIDTH/SCREEN_HEIGHT defaults and the RGB332 colour codes (blue 8'h03, red 8'hE0, white 8'hFF) shall live in a shared package used by this block and the image processor.
REQ-031 The block shall be a single module; no sub-module.

Verification
REQ-032 Bytes 8'hF8,8'h00 in one HREF window after VSYNC fall -> W_EN once, PIXEL_OUT 8'hE0, X_ADDR 0, Y_ADDR 0.
REQ-033 Bytes 8'h00,8'h1F -> PIXEL_OUT 8'h03; bytes 8'hFF,8'hFF -> 8'hFF; second pixel at X_ADDR 1.
REQ-034 Line of 200 pixels -> exactly 176 W_EN pulses, X_ADDR last 175; next line Y_ADDR 1, X_ADDR 0.
REQ-035 Frame of 150 lines then VSYNC rise -> last write Y_ADDR 143, one FRAME_DONE pulse, next frame starts at (0,0).
REQ-036 HREF high for 3 bytes -> one write, third byte discarded, next line starts at phase 0.
REQ-037 RESET_N low after first byte of a pixel -> outputs zero at once, no write until a new VSYNC fall and two fresh bytes.

Source files
------------

// File: rtl/camera_downsampler_pkg.sv
// camera_downsampler_pkg: shared frame geometry, RGB332 colour codes and capture states
//   DEF_SCREEN_WIDTH / DEF_SCREEN_HEIGHT : default frame-buffer geometry
//   RGB_BLUE / RGB_RED / RGB_WHITE       : RGB332 colour codes shared with the image processor
//   cam_state_t                          : capture state machine encoding
package camera_downsampler_pkg;
  localparam int DEF_SCREEN_WIDTH = 176;
  localparam int DEF_SCREEN_HEIGHT = 144;
  localparam logic [7:0] RGB_BLUE = 8'h03;
  localparam logic [7:0] RGB_RED = 8'hE0;
  localparam logic [7:0] RGB_WHITE = 8'hFF;
  typedef enum logic {WAIT_FRAME, CAPTURE} cam_state_t;
endpackage

// File: rtl/camera_downsampler.sv
// camera_downsampler: RGB565 camera byte stream to RGB332 frame-buffer writes
//   clk        : camera pixel clock
//   reset_n    : asynchronous active-low reset
//   cam_data   : RGB565 byte bus, high byte first
//   cam_href   : line valid
//   cam_vsync  : vertical blanking, rising edge ends a frame
//   pixel_out  : RGB332 pixel, x_addr/y_addr its coordinates, w_en its write strobe
//   frame_done : one-cycle pulse at each frame end
module camera_downsampler
  import camera_downsampler_pkg::*;
#(
  parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cam_data,
  input  logic       cam_href,
  input  logic       cam_vsync,
  output logic [7:0] pixel_out,
  output logic       w_en,
  output logic [7:0] x_addr,
  output logic [7:0] y_addr,
  output logic       frame_done
);
  localparam logic [7:0] W_MAX = 8'(SCREEN_WIDTH);
  localparam logic [7:0] H_MAX = 8'(SCREEN_HEIGHT);
  cam_state_t state, state_nx;
  logic href_q, vsync_q, phase;
  logic [2:0] r, g;
  logic [7:0] col, row;
  logic capture, vsync_rise, vsync_fall, href_fall, active, line_end, pix_done, wr;
  always_comb begin
    capture = state == CAPTURE;
    vsync_rise = cam_vsync & ~vsync_q;
    vsync_fall = ~cam_vsync & vsync_q;
    href_fall = ~cam_href & href_q;
    // a line window that overlaps vertical blanking is ignored entirely, including its falling edge
    active = capture & cam_href & ~cam_vsync;
    line_end = capture & href_fall & ~cam_vsync;
    pix_done = active & phase;
    wr = pix_done & (col < W_MAX) & (row < H_MAX);
    state_nx = (state == WAIT_FRAME && vsync_fall) ? CAPTURE : state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_FRAME;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      href_q <= 1'b0;
      vsync_q <= 1'b0;
      phase <= 1'b0;
      r <= '0;
      g <= '0;
      col <= '0;
      row <= '0;
      pixel_out <= '0;
      x_addr <= '0;
      y_addr <= '0;
      w_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      href_q <= cam_href;
      vsync_q <= cam_vsync;
      w_en <= wr;
      frame_done <= capture & vsync_rise;
      if (capture & vsync_rise) begin
        col <= '0;
        row <= '0;
        phase <= 1'b0;
      end else if (line_end) begin
        col <= '0;
        phase <= 1'b0;
        row <= (row == H_MAX) ? row : row + 8'd1;
      end else if (active) begin
        phase <= ~phase;
        if (!phase) begin
          r <= cam_data[7:5];
          g <= cam_data[2:0];
        end else if (col != W_MAX) begin
          col <= col + 8'd1;
        end
      end
      if (wr) begin
        pixel_out <= {r, g, cam_data[4:3]};
        x_addr <= col;
        y_addr <= row;
      end
    end
  end
endmodule

// File: tb/tb_camera_downsampler.sv
// tb_camera_downsampler: randomized line/frame stimulus checked against a pixel-list reference model
module tb_camera_downsampler;
  import camera_downsampler_pkg::*;
  localparam int W = DEF_SCREEN_WIDTH;
  localparam int H = DEF_SCREEN_HEIGHT;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] cam_data = '0;
  logic cam_href = 1'b0;
  logic cam_vsync = 1'b0;
  logic [7:0] pixel_out, x_addr, y_addr;
  logic w_en, frame_done;
  int total = 0, bad = 0;
  logic [23:0] obs[$], exp_q[$];
  logic [23:0] last_obs = '0;
  int n_obs = 0, fd_cnt = 0, exp_fd = 0, row_m = 0;
  bit capturing = 0;
  logic [7:0] lb[$];

  camera_downsampler dut (
    .clk(clk), .reset_n(reset_n), .cam_data(cam_data), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .pixel_out(pixel_out), .w_en(w_en), .x_addr(x_addr), .y_addr(y_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en) obs.push_back({pixel_out, x_addr, y_addr});
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) chk(tag, obs[i], exp_q[i]);
    n_obs = obs.size();
    if (n_obs > 0) last_obs = obs[$];
    obs.delete();
    exp_q.delete();
  endtask

  // Reference: each pair of bytes in a window is one RGB565 pixel; each channel is truncated to its RGB332 width.
  function automatic logic [7:0] to332(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w = {hi, lo};
    int rr = int'(w[15:11]) / 4;
    int gg = int'(w[10:5]) / 8;
    int bb = int'(w[4:0]) / 8;
    return 8'(rr * 32 + gg * 4 + bb);
  endfunction

  task automatic run_line(input bit vs_end);
    bit vh = cam_vsync;
    for (int i = 0; i < lb.size(); i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = lb[i];
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    if (vs_end) cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    if (capturing && !vh) begin
      for (int k = 0; k < lb.size() / 2; k++)
        if (k < W && row_m < H) exp_q.push_back({to332(lb[2*k], lb[2*k+1]), 8'(k), 8'(row_m)});
      if (vs_end) begin
        row_m = 0;
        exp_fd++;
      end else row_m = (row_m < H) ? row_m + 1 : H;
    end
  endtask

  task automatic rand_line(input int nbytes);
    lb.delete();
    for (int i = 0; i < nbytes; i++) lb.push_back(8'($urandom));
  endtask

  task automatic vs_rise();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    if (capturing) begin
      row_m = 0;
      exp_fd++;
    end
  endtask

  task automatic vs_fall();
    @(negedge clk);
    cam_vsync = 1'b0;
    repeat (2) @(negedge clk);
    capturing = 1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix"}, pixel_out, 0);
    chk({tag, "_wen"}, w_en, 0);
    chk({tag, "_x"}, x_addr, 0);
    chk({tag, "_y"}, y_addr, 0);
    chk({tag, "_fd"}, frame_done, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    rand_line(8);
    run_line(0);
    check_writes("wait_ignores_href");
    vs_rise();
    vs_fall();
    fd_cnt = 0;
    lb = '{8'hF8, 8'h00};
    run_line(0);
    check_writes("red");
    chk("red_n", n_obs, 1);
    chk("red_val", last_obs, {RGB_RED, 8'd0, 8'd0});
    lb = '{8'h00, 8'h1F, 8'hFF, 8'hFF};
    run_line(0);
    chk("blue_val", obs.size() > 0 ? obs[0] : 24'h0, {RGB_BLUE, 8'd0, 8'd1});
    check_writes("blue_white");
    chk("white_val", last_obs, {RGB_WHITE, 8'd1, 8'd1});
    rand_line(3);
    run_line(0);
    check_writes("three_bytes");
    chk("three_bytes_n", n_obs, 1);
    lb = '{8'hF8, 8'h00, 8'h00, 8'h1F};
    run_line(0);
    check_writes("phase_restart");
    rand_line(400);
    run_line(0);
    check_writes("long_line");
    chk("long_line_n", n_obs, W);
    chk("long_line_last_x", last_obs[15:8], W - 1);
    rand_line(6);
    run_line(0);
    check_writes("after_long");
    chk("after_long_first", n_obs, 3);
    vs_rise();
    chk("fd_once", fd_cnt, exp_fd);
    rand_line(6);
    run_line(0);
    check_writes("href_in_vsync");
    vs_fall();
    for (int l = 0; l < 150; l++) begin
      rand_line(4);
      run_line(0);
      check_writes("frame");
    end
    chk("frame_last_y", last_obs[7:0], H - 1);
    vs_rise();
    chk("frame_fd", fd_cnt, exp_fd);
    vs_fall();
    rand_line(4);
    run_line(0);
    check_writes("new_frame");
    chk("new_frame_origin", last_obs[15:0], {8'd1, 8'd0});
    rand_line(4);
    run_line(0);
    rand_line(4);
    run_line(1);
    check_writes("href_fall_vsync_rise");
    chk("coincident_fd", fd_cnt, exp_fd);
    vs_fall();
    rand_line(2);
    run_line(0);
    check_writes("after_coincident");
    chk("after_coincident_origin", last_obs[15:0], 16'h0);
    @(negedge clk);
    cam_href = 1'b1;
    cam_data = 8'hFF;
    @(negedge clk);
    cam_data = 8'hFF;
    @(negedge clk);
    cam_data = 8'hAA;
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.push_back({8'hFF, 8'd0, 8'(row_m)});
    #1;
    chk_reset_outputs("mid_reset");
    check_writes("before_reset");
    capturing = 0;
    row_m = 0;
    @(negedge clk);
    cam_href = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rand_line(6);
    run_line(0);
    check_writes("after_reset_wait");
    vs_rise();
    vs_fall();
    rand_line(4);
    run_line(0);
    check_writes("restart");
    chk("restart_n", n_obs, 2);
    chk("final_fd", fd_cnt, exp_fd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
